// File: rtl/pm_sweep_scheduler_if.sv
// APB master port and result stream of the process-monitor sweep scheduler.
// The scheduler connects through the master modport; the controller/consumer side uses slave.
interface pm_sweep_scheduler_if;
    logic [4:0]  m_paddr;
    logic        m_psel;
    logic        m_penable;
    logic        m_pwrite;
    logic [31:0] m_pwdata;
    logic [31:0] m_prdata;
    logic        m_pready;
    logic        m_pslverr;
    logic        res_valid;
    logic        res_ready;
    logic [5:0]  res_sensor;
    logic [31:0] res_data;
    logic        res_err;

    modport master (
        output m_paddr, m_psel, m_penable, m_pwrite, m_pwdata,
        input  m_prdata, m_pready, m_pslverr,
        output res_valid, res_sensor, res_data, res_err,
        input  res_ready
    );

    modport slave (
        input  m_paddr, m_psel, m_penable, m_pwrite, m_pwdata,
        output m_prdata, m_pready, m_pslverr,
        input  res_valid, res_sensor, res_data, res_err,
        output res_ready
    );
endinterface

// File: rtl/pm_sweep_scheduler.sv
// Autonomous sweep sequencer: drives the process-monitor controller over APB, one sensor
// at a time, and streams each sensor's status word (or an error marker) on a valid/ready port.
module pm_sweep_scheduler #(
    parameter int NSENS   = 4,
    parameter int TIMEOUT = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [NSENS-1:0]     sens_mask,
    input  logic [31:0]          ref_count,
    input  logic [15:0]          interval,
    input  logic                 dataready,
    output logic                 busy,
    output logic                 sweep_done,
    pm_sweep_scheduler_if.master bus
);
    localparam int              WD_W   = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

    typedef enum logic [3:0] {
        IDLE, SELECT, WREF, WCTL, ARM, WAIT, RD, PUSH, GAP
    } state_t;

    state_t           state_q, state_d;
    logic [NSENS-1:0] mask_q, mask_d;
    logic [31:0]      ref_q, ref_d;
    logic [5:0]       idx_q, idx_d;
    logic             err_q, err_d;
    logic             acc_q, acc_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic [15:0]      gap_q, gap_d;
    logic [31:0]      data_q, data_d;
    logic             dr_meta_q, dr_s_q;

    logic             found;
    logic [5:0]       hit;
    logic             apb_done;
    logic             apb_err;

    // Lowest pending sensor at or above the current index; loop runs high-to-low so the lowest wins.
    always_comb begin
        found = 1'b0;
        hit   = '0;
        for (int i = NSENS - 1; i >= 0; i--) begin
            if (mask_q[i] && (6'(i) >= idx_q)) begin
                found = 1'b1;
                hit   = 6'(i);
            end
        end
    end

    assign apb_done = acc_q && bus.m_pready;
    assign apb_err  = apb_done && bus.m_pslverr;
    assign busy     = (state_q != IDLE);

    always_comb begin
        state_d        = state_q;
        mask_d         = mask_q;
        ref_d          = ref_q;
        idx_d          = idx_q;
        err_d          = err_q;
        acc_d          = acc_q;
        wd_d           = wd_q;
        gap_d          = gap_q;
        data_d         = data_q;
        sweep_done     = 1'b0;
        bus.m_psel     = 1'b0;
        bus.m_penable  = 1'b0;
        bus.m_pwrite   = 1'b0;
        bus.m_paddr    = 5'h00;
        bus.m_pwdata   = 32'h0;
        bus.res_valid  = 1'b0;
        bus.res_sensor = 6'h0;
        bus.res_data   = 32'h0;
        bus.res_err    = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    mask_d  = sens_mask;
                    ref_d   = ref_count;
                    idx_d   = '0;
                    state_d = SELECT;
                end
            end
            SELECT: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (found) begin
                    idx_d   = hit;
                    mask_d  = mask_q & ~(NSENS'(1) << hit);
                    state_d = WREF;
                end else begin
                    sweep_done = 1'b1;
                    gap_d      = interval;
                    state_d    = GAP;
                end
            end
            WREF, WCTL, RD: begin
                // Address/data are pure functions of the state, so they hold for the whole transfer.
                bus.m_psel    = 1'b1;
                bus.m_penable = acc_q;
                acc_d         = !apb_done;
                if (state_q == WREF) begin
                    bus.m_pwrite = 1'b1;
                    bus.m_paddr  = 5'h08;
                    bus.m_pwdata = ref_q;
                end else if (state_q == WCTL) begin
                    bus.m_pwrite = 1'b1;
                    bus.m_paddr  = 5'h04;
                    bus.m_pwdata = {16'h0, 1'b1, 9'h0, idx_q};
                end else begin
                    bus.m_paddr  = 5'h0C;
                end
                if (apb_err) begin
                    err_d   = 1'b1;
                    data_d  = 32'h0;
                    state_d = PUSH;
                end else if (apb_done) begin
                    case (state_q)
                        WREF:    state_d = WCTL;
                        WCTL: begin
                            wd_d    = '0;
                            state_d = ARM;
                        end
                        default: begin
                            data_d  = bus.m_prdata;
                            state_d = PUSH;
                        end
                    endcase
                end
            end
            ARM, WAIT: begin
                // ARM waits out the previous measurement's stale done flag before WAIT looks for a new one.
                if (wd_q == WD_MAX) begin
                    err_d   = 1'b1;
                    data_d  = 32'h0;
                    state_d = PUSH;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                    if (state_q == ARM && !dr_s_q) begin
                        state_d = WAIT;
                    end else if (state_q == WAIT && dr_s_q) begin
                        state_d = RD;
                    end
                end
            end
            PUSH: begin
                bus.res_valid  = 1'b1;
                bus.res_sensor = idx_q;
                bus.res_data   = data_q;
                bus.res_err    = err_q;
                if (bus.res_ready) begin
                    err_d   = 1'b0;
                    state_d = enable ? SELECT : IDLE;
                end
            end
            GAP: begin
                if (!enable || gap_q == 16'd0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            mask_q    <= '0;
            ref_q     <= '0;
            idx_q     <= '0;
            err_q     <= 1'b0;
            acc_q     <= 1'b0;
            wd_q      <= '0;
            gap_q     <= '0;
            data_q    <= '0;
            dr_meta_q <= 1'b0;
            dr_s_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            ref_q     <= ref_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
            acc_q     <= acc_d;
            wd_q      <= wd_d;
            gap_q     <= gap_d;
            data_q    <= data_d;
            dr_meta_q <= dataready;
            dr_s_q    <= dr_meta_q;
        end
    end
endmodule

// File: doc/pm_sweep_scheduler.md
# pm_sweep_scheduler

Autonomous sweep sequencer for the process-monitor master controller. It acts as an APB master on the controller's APB slave port while the controller runs in APB mode. For each enabled sensor it programs the reference counter, starts a measurement, waits for `dataready`, reads the sensor status word and streams it out on a valid/ready result port. Sweeps repeat at a programmable interval, so software only consumes results instead of driving the measurement protocol.

## Interface
- `NSENS`, 4: number of sensors; 1..63; width of `sens_mask`.
- `TIMEOUT`, 65535: cycles to wait for `dataready` before a measurement is declared failed; at least 16.
- `clk` in 1: single clock; also drives the controller's `pclk`.
- `rst` in 1: reset, asynchronous, active-high.
- `enable` in 1: run sweeps while high.
- `sens_mask` in NSENS: bit i set measures sensor i; sampled at sweep start.
- `ref_count` in 32: value written to REF_COUNTER; sampled at sweep start.
- `interval` in 16: idle cycles between sweeps; sampled at sweep end.
- `m_paddr` out 5: APB address, one of 5'h08 (REF_COUNTER), 5'h04 (SENS_CTRL), 5'h0C (SENS_STAT).
- `m_psel`, `m_penable`, `m_pwrite` out 1 each: APB control.
- `m_pwdata` out 32: APB write data.
- `m_prdata` in 32: APB read data.
- `m_pready`, `m_pslverr` in 1 each: APB response.
- `dataready` in 1: controller measurement-done flag; asynchronous to `clk`.
- `res_valid` out 1, `res_ready` in 1: result handshake.
- `res_sensor` out 6: sensor index of the result.
- `res_data` out 32: SENS_STAT word, or 0 on error.
- `res_err` out 1: pslverr or timeout occurred for this sensor.
- `busy` out 1: high in every state except IDLE.
- `sweep_done` out 1: one-cycle pulse at the end of each sweep.

## Operation
- `dataready` passes through a 2-flop synchronizer (`dr_s`) before any use.
- States: IDLE, SELECT, WREF, WCTL, ARM, WAIT, RD, PUSH, GAP.
- **IDLE**
  - When `enable` is high, capture `sens_mask` into `mask_q` and `ref_count` into `ref_q`, set `idx = 0`, then go to SELECT.
- **SELECT**
  - Scan from `idx` for the lowest set bit of `mask_q`; one cycle per state entry, using a combinational priority search.
  - If a bit is found: `idx` takes that index, clear the bit in `mask_q`, go to WREF.
  - If none is found: pulse `sweep_done`, load the gap counter from `interval`, go to GAP.
- **WREF**: APB write `ref_q` to 5'h08.
- **WCTL**: APB write {16'h0, 1'b1 (bit15 start), 9'h0, idx[5:0]} to 5'h04.
- **APB transfers**
  - Setup cycle: `psel=1`, `penable=0`.
  - Access cycles: `psel=1`, `penable=1` until `m_pready`.
  - Address, data and `pwrite` are stable for the whole transfer.
  - If `m_pslverr` is high with `m_pready`: set `err_q`, skip the remaining steps for this sensor and go to PUSH with data 0.
- **ARM**
  - Wait for `dr_s == 0`, so the previous measurement's done flag is not taken as completion.
  - Then go to WAIT.
- **WAIT**: wait for `dr_s == 1`, then go to RD.
- **Timeout in ARM/WAIT**
  - The watchdog counter starts at 0 on entry to ARM and runs through ARM and WAIT.
  - On reaching `TIMEOUT`: set `err_q`, go to PUSH with data 0. No RD transfer is issued.
- **RD**: APB read from 5'h0C; capture `m_prdata` into `res_data` when `m_pready` is high.
- **PUSH**
  - Assert `res_valid` with `res_sensor = idx`, `res_data`, `res_err = err_q`.
  - On `res_ready`: clear `err_q`.
    - If `enable` is high, go to SELECT.
    - If `enable` is low, go to IDLE; the rest of the sweep is abandoned and `sweep_done` is not pulsed.
- **GAP**
  - Counter counts down to 0, then go to IDLE (IDLE restarts immediately if `enable` is high).
  - `interval == 0` gives GAP for exactly one cycle.
- **Deassertion of `enable`**: takes effect only in SELECT, PUSH, GAP and IDLE. An in-flight APB transfer or measurement always completes and its result is always pushed.

## Timing
- **Reset values**: all outputs 0 (`m_paddr`, `m_pwdata`, `res_*`, `busy`, `sweep_done`, APB controls); state IDLE; synchronizer flops 0.
- **Sweep start**: `enable` rising edge to the first `m_psel` of WREF takes 2 cycles (IDLE, then SELECT).
- **APB write** with zero wait states: 2 cycles. Each `m_pready`-low cycle adds 1.
- **Results**: `res_valid` rises the cycle after RD completes; data is held stable while `res_valid && !res_ready`; no result is dropped or duplicated.
- **Back-to-back sensors**: PUSH handshake cycle, then SELECT (1 cycle), then WREF setup.
- **Synchronizer latency**: `dataready` edges become visible 2–3 cycles late.
- **Mask/config changes mid-sweep** take effect at the next sweep only.

## Test plan
- **Full sweep**
  - Stimulus: NSENS=4, mask=4'b1011, ref=32'h100, slave model asserts `dataready` 20 cycles after the CTRL write with stat = 32'hA000_0000 + idx.
  - Response: writes 08/04/read 0C per sensor, in order 0, 1, 3. Results {0, A0000000}, {1, A0000001}, {3, A0000003}, all with err 0. One `sweep_done` after the third result.
- **Backpressure**
  - Stimulus: `res_ready` low for 10 cycles on the first result.
  - Response: `res_valid`/`res_data` held constant; no APB activity until the handshake.
- **Timeout**
  - Stimulus: TIMEOUT=16, `dataready` never rises for sensor 1.
  - Response: sensor 1 result has err=1, data=0, no 0C read; sensor 3 is still measured.
- **pslverr**
  - Stimulus: `m_pslverr` on the SENS_CTRL write for sensor 0.
  - Response: err result for sensor 0 with no ARM wait; the sweep continues.
- **Gap and empty mask**
  - Stimulus: interval=5 with mask=0.
  - Response: `sweep_done` pulses every 8 cycles (IDLE + SELECT + 6 GAP); no APB transfers.
- **Reset and disable mid-operation**
  - Stimulus: `rst` asserted during a WAIT access.
  - Response: all outputs 0 on the same edge.
  - Stimulus: `enable` dropped during WAIT.
  - Response: the measurement completes and is pushed, then IDLE with `busy=0` and no `sweep_done`.
